// File: rtl/pong_pkg.sv
// Shared VGA 640x480@60 timing constants, static object bounds and colours for the pong display.
package pong_pkg;

    localparam int unsigned CW      = 10;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned DIV_W   = 2;
    localparam int unsigned DIV_MAX = 3;

    localparam int unsigned H_DISP  = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_DISP + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int unsigned V_DISP  = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_DISP + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned WALL_X_L = 32;
    localparam int unsigned WALL_X_R = 35;

    localparam int unsigned PAD_X_L = 600;
    localparam int unsigned PAD_X_R = 603;
    localparam int unsigned PAD_Y_T = 204;
    localparam int unsigned PAD_Y_B = 276;

    localparam int unsigned BALL_X_L = 580;
    localparam int unsigned BALL_X_R = 588;
    localparam int unsigned BALL_Y_T = 238;
    localparam int unsigned BALL_Y_B = 246;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t BG_RGB   = 12'h000;
    localparam rgb_t WALL_RGB = 12'h070;
    localparam rgb_t PAD_RGB  = 12'h770;
    localparam rgb_t BALL_RGB = 12'hF0F;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    // Inclusive range test on a pixel coordinate.
    function automatic logic in_range(input logic [CW-1:0] v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (v >= CW'(lo)) && (v <= CW'(hi));
    endfunction

endpackage

// File: rtl/vga_sync.sv
// Pixel-tick divider, horizontal/vertical counters and combinational sync/video_on decode.
module vga_sync
    import pong_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output sync_t         sync_c
);

    logic [DIV_W-1:0] div_q;
    logic [CW-1:0]    x_q;
    logic [CW-1:0]    y_q;
    logic [CW-1:0]    x_d;
    logic [CW-1:0]    y_d;
    logic             tick_c;

    assign tick_c  = (div_q == DIV_W'(DIV_MAX));
    assign pixel_x = x_q;
    assign pixel_y = y_q;

    // Counters advance once per tick; pixel_y moves only on the pixel_x wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick_c) begin
            if (x_q == CW'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    always_comb begin
        sync_c          = '0;
        sync_c.hsync    = !in_range(x_q, H_SYNC_START, H_SYNC_END);
        sync_c.vsync    = !in_range(y_q, V_SYNC_START, V_SYNC_END);
        sync_c.video_on = (x_q < CW'(H_DISP)) && (y_q < CW'(V_DISP));
    end

endmodule

// File: rtl/pong_top.sv
// Static pong screen: wall, paddle and optional ball (PONG_BALL_EN) over VGA 640x480 timing.
module pong_top
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    sync_t         sync_c;
    logic          wall_c;
    logic          pad_c;
    logic          ball_c;
    rgb_t          rgb_c;

    vga_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .sync_c  (sync_c)
    );

    assign wall_c = in_range(pixel_x, WALL_X_L, WALL_X_R);
    assign pad_c  = in_range(pixel_x, PAD_X_L, PAD_X_R) && in_range(pixel_y, PAD_Y_T, PAD_Y_B);

`ifdef PONG_BALL_EN
    assign ball_c = in_range(pixel_x, BALL_X_L, BALL_X_R) && in_range(pixel_y, BALL_Y_T, BALL_Y_B);
`else
    assign ball_c = 1'b0;
`endif

    // Object priority: wall over paddle over ball; blanked outside the display area.
    always_comb begin
        rgb_c = BG_RGB;
        if (sync_c.video_on) begin
            if (wall_c) begin
                rgb_c = WALL_RGB;
            end else if (pad_c) begin
                rgb_c = PAD_RGB;
            end else if (ball_c) begin
                rgb_c = BALL_RGB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= BG_RGB;
        end else begin
            hsync <= sync_c.hsync;
            vsync <= sync_c.vsync;
            rgb   <= rgb_c;
        end
    end

endmodule

// File: tb/tb_pong_top.sv
// Bench for pong_top: cycle scoreboard against a reference position model plus directed pixel probes.
module tb_pong_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    pong_top dut (
        .clk   (clk),
        .rst   (rst),
        .hsync (hsync),
        .vsync (vsync),
        .rgb   (rgb)
    );

    always #5 clk = ~clk;

`ifdef PONG_BALL_EN
    localparam logic [11:0] BALL_EXP = 12'hF0F;
`else
    localparam logic [11:0] BALL_EXP = 12'h000;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [13:0] sb_q[$];
    int unsigned mdiv = 0;
    int unsigned mx = 0;
    int unsigned my = 0;
    int unsigned hs_low = 0;
    int unsigned vs_low = 0;
    logic [9:0]  jx = '0;
    logic [9:0]  jy = '0;

    // Expected {hsync, vsync, rgb} for a given counter position.
    function automatic logic [13:0] exp_out(input int unsigned x, input int unsigned y);
        logic        hs;
        logic        vs;
        logic [11:0] c;
        hs = !(x >= 656 && x <= 751);
        vs = !(y >= 490 && y <= 491);
        c  = 12'h000;
        if (x < 640 && y < 480) begin
            if (x >= 32 && x <= 35)
                c = 12'h070;
            else if (x >= 600 && x <= 603 && y >= 204 && y <= 276)
                c = 12'h770;
            else if (x >= 580 && x <= 588 && y >= 238 && y <= 246)
                c = BALL_EXP;
        end
        return {hs, vs, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk: push the expectation, clock, advance the model, pop and compare.
    task automatic step();
        logic [13:0] e;
        logic [13:0] o;
        e = (rst == 1'b0) ? 14'h3000 : exp_out(mx, my);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst == 1'b0) begin
            mdiv = 0;
            mx   = 0;
            my   = 0;
        end else begin
            if (mdiv == 3) begin
                if (mx == 799) begin
                    mx = 0;
                    my = (my == 524) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            mdiv = (mdiv + 1) % 4;
        end
        o = {hsync, vsync, rgb};
        if (hsync == 1'b0) hs_low++;
        if (vsync == 1'b0) vs_low++;
        e = sb_q.pop_front();
        check("out", 32'(o), 32'(e));
        check("pos", 32'({dut.pixel_x, dut.pixel_y}), 32'({10'(mx), 10'(my)}));
    endtask

    // Relocate the counters, held across a non-tick edge so the registers keep the new value.
    task jump(input int unsigned x, input int unsigned y);
        if (mdiv == 3) step();
        jx = 10'(x);
        jy = 10'(y);
        mx = x;
        my = y;
        force dut.u_sync.x_q = jx;
        force dut.u_sync.y_q = jy;
        step();
        release dut.u_sync.x_q;
        release dut.u_sync.y_q;
    endtask

    task automatic run_until(input int unsigned x, input int unsigned y, input int unsigned max_cyc);
        int unsigned n;
        logic        reached;
        n = 0;
        while (!(mx == x && my == y) && n < max_cyc) begin
            step();
            n++;
        end
        reached = (mx == x && my == y);
        check("reach", 32'(reached), 32'd1);
    endtask

    task automatic probe(input string tag, input int unsigned x, input int unsigned y,
                         input logic [11:0] exp);
        jump(x, y);
        check(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        repeat (10) step();
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_rgb", 32'(rgb), 32'h000);

        rst = 1'b1;
        repeat (3) step();
        check("px_before_tick", 32'(dut.pixel_x), 32'd0);
        step();
        check("px_first_tick", 32'(dut.pixel_x), 32'd1);

        hs_low = 0;
        run_until(0, 1, 3300);
        check("hsync_low_clks", 32'(hs_low), 32'd384);
        check("px_wrap", 32'(dut.pixel_x), 32'd0);
        check("py_inc", 32'(dut.pixel_y), 32'd1);

        jump(655, 10);
        check("hs_655", 32'(hsync), 32'd1);
        jump(656, 10);
        check("hs_656", 32'(hsync), 32'd0);
        jump(751, 10);
        check("hs_751", 32'(hsync), 32'd0);
        jump(752, 10);
        check("hs_752", 32'(hsync), 32'd1);

        probe("wall_31", 31, 100, 12'h000);
        probe("wall_32", 32, 100, 12'h070);
        probe("wall_35", 35, 100, 12'h070);
        probe("wall_36", 36, 100, 12'h000);

        probe("pad_204", 600, 204, 12'h770);
        probe("pad_276", 603, 276, 12'h770);
        probe("pad_203", 600, 203, 12'h000);
        probe("pad_277", 600, 277, 12'h000);
        probe("pad_604", 604, 240, 12'h000);

        probe("ball_580", 580, 240, BALL_EXP);
        probe("ball_588", 588, 240, BALL_EXP);
        probe("ball_238", 584, 238, BALL_EXP);
        probe("ball_246", 584, 246, BALL_EXP);
        probe("ball_589", 589, 240, 12'h000);
        probe("ball_237", 584, 237, 12'h000);

        probe("blank_x640", 640, 100, 12'h000);
        probe("blank_y480", 33, 480, 12'h000);
        probe("blank_corner", 799, 524, 12'h000);

        jump(570, 240);
        run_until(610, 240, 200);

        jump(790, 487);
        vs_low = 0;
        run_until(0, 494, 25000);
        check("vsync_low_clks", 32'(vs_low), 32'd6400);

        jump(795, 524);
        run_until(0, 0, 100);
        check("py_wrap", 32'(dut.pixel_y), 32'd0);

        jump(300, 300);
        rst = 1'b0;
        step();
        check("midrst_px", 32'(dut.pixel_x), 32'd0);
        check("midrst_py", 32'(dut.pixel_y), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'h000);
        rst = 1'b1;
        repeat (4) step();
        check("midrst_tick", 32'(dut.pixel_x), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
